lfsr_rng: RTL and testbench

Parametrised Galois LFSR pseudo-random word source for NoC traffic generation. It succeeds the fixed 8-bit shifter with a configurable width and tap mask, several shifts per word, runtime seed load, and a valid/ready output stream. It also detects lock-up and period wrap. It sits between the traffic-pattern controller (enable, seed) and packet injectors (consumer of O_DATA).

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_galois_step.sv | 20 ++
 rtl/lfsr_rng.sv | 140 ++++++++++++++
 tb/tb_lfsr_rng.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types, legality limits and the single-shift Galois step for the LFSR generators.
package lfsr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  localparam int LFSR_DW_MIN = 3;
  localparam int LFSR_DW_MAX = 64;
  localparam int STEPS_MIN   = 1;

  // Operates at the widest legal width; callers zero-extend and truncate back.
  function automatic logic [LFSR_DW_MAX-1:0] galois_step(
    input logic [LFSR_DW_MAX-1:0] s,
    input logic [LFSR_DW_MAX-1:0] taps
  );
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/lfsr_galois_step.sv
// Combinational STEPS-fold Galois LFSR advance; zero latency, no flow control.
module lfsr_galois_step
  import lfsr_pkg::*;
#(
  parameter int                 LFSR_DW = 16,
  parameter logic [LFSR_DW-1:0] TAPS    = 16'hB400,
  parameter int                 STEPS   = 1
) (
  input  logic [LFSR_DW-1:0] i_state,
  output logic [LFSR_DW-1:0] o_next
);

  always_comb begin
    o_next = i_state;
    for (int k = 0; k < STEPS; k++) begin
      o_next = LFSR_DW'(galois_step(64'(o_next), 64'(TAPS)));
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// Galois LFSR word source with seed load, wrap/lock-up detection and a valid/ready output.
// Output comes straight from the state register; a stalled word holds until accepted.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int                 LFSR_DW      = 16,
  parameter logic [LFSR_DW-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = 16'h0001,
  parameter int                 OUT_DW       = 8,
  parameter int                 STEPS        = 1,
  parameter int                 CNT_DW       = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                I_EN,
  input  logic                I_SEED_VLD,
  input  logic [LFSR_DW-1:0]  I_SEED,
  input  logic                I_RDY,
  output logic                O_VLD,
  output logic [OUT_DW-1:0]   O_DATA,
  output logic                O_WRAP,
  output logic                O_LOCKUP,
  output logic                O_SEED_ERR,
  output logic [CNT_DW-1:0]   O_WORD_CNT
);

  if (LFSR_DW < LFSR_DW_MIN || LFSR_DW > LFSR_DW_MAX) begin : g_bad_dw
    $error("lfsr_rng: LFSR_DW out of range");
  end
  if (OUT_DW > LFSR_DW) begin : g_bad_out_dw
    $error("lfsr_rng: OUT_DW exceeds LFSR_DW");
  end
  if (LFSR_DEFAULT == '0) begin : g_bad_default
    $error("lfsr_rng: LFSR_DEFAULT must be non-zero");
  end
  if (STEPS < STEPS_MIN || STEPS > LFSR_DW) begin : g_bad_steps
    $error("lfsr_rng: STEPS out of range");
  end

  fsm_t               r_fsm;
  fsm_t               w_fsm_nxt;
  logic [LFSR_DW-1:0] r_state;
  logic [LFSR_DW-1:0] r_seed_q;
  logic [LFSR_DW-1:0] w_adv;
  logic [LFSR_DW-1:0] w_seed_val;
  logic [CNT_DW-1:0]  r_cnt;
  logic               r_wrap;
  logic               r_lockup;
  logic               r_seed_err;
  logic               w_hs;
  logic               w_load;
  logic               w_seed_err;
  logic               w_lock_run;

  lfsr_galois_step #(
    .LFSR_DW (LFSR_DW),
    .TAPS    (TAPS),
    .STEPS   (STEPS)
  ) u_step (
    .i_state (r_state),
    .o_next  (w_adv)
  );

  assign w_seed_val = (I_SEED == '0) ? LFSR_DEFAULT : I_SEED;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // A seed strobe outranks I_EN in IDLE; RUN only exits on an accepted word.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_hs       = 1'b0;
    w_load     = 1'b0;
    w_seed_err = 1'b0;
    w_lock_run = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (I_SEED_VLD) begin
          w_load = 1'b1;
        end else if (I_EN) begin
          w_fsm_nxt = RUN;
        end
      end
      RUN: begin
        w_hs       = I_RDY;
        w_seed_err = I_SEED_VLD;
        w_lock_run = (r_state == '0);
        if (I_RDY && !I_EN) begin
          w_fsm_nxt = IDLE;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= LFSR_DEFAULT;
      r_seed_q   <= LFSR_DEFAULT;
      r_cnt      <= '0;
      r_wrap     <= 1'b0;
      r_lockup   <= 1'b0;
      r_seed_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_lockup   <= 1'b0;
      r_seed_err <= w_seed_err;
      if (w_load) begin
        r_state  <= w_seed_val;
        r_seed_q <= w_seed_val;
        r_cnt    <= '0;
        r_lockup <= (I_SEED == '0);
      end else if (w_lock_run) begin
        // Zero state is a dead orbit; recovery wins over the advance.
        r_state  <= LFSR_DEFAULT;
        r_lockup <= 1'b1;
        if (w_hs) begin
          r_cnt <= r_cnt + CNT_DW'(1);
        end
      end else if (w_hs) begin
        r_state <= w_adv;
        r_cnt   <= r_cnt + CNT_DW'(1);
        r_wrap  <= (w_adv == r_seed_q);
      end
    end
  end

  assign O_VLD      = (r_fsm == RUN);
  assign O_DATA     = r_state[OUT_DW-1:0];
  assign O_WRAP     = r_wrap;
  assign O_LOCKUP   = r_lockup;
  assign O_SEED_ERR = r_seed_err;
  assign O_WORD_CNT = r_cnt;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: 4-bit LFSR, taps 4'hC, with a second STEPS=2 instance.
module tb_lfsr_rng;

  logic       CLK = 1'b0;
  logic       RST;
  logic       I_EN;
  logic       I_SEED_VLD;
  logic [3:0] I_SEED;
  logic       I_RDY;

  logic       o1_vld, o1_wrap, o1_lock, o1_serr;
  logic [3:0] o1_data;
  logic [7:0] o1_cnt;
  logic       o2_vld, o2_wrap, o2_lock, o2_serr;
  logic [3:0] o2_data;
  logic [7:0] o2_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       sv;
    logic [3:0] seed;
    logic       rdy;
    logic       vld;
    logic [3:0] data;
    logic       wrap;
    logic       lock;
    logic       serr;
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];

  // Hand-derived Galois sequences for taps 4'hC.
  logic [3:0] seq_a [13] = '{4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7, 4'hF,
                              4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
  logic [3:0] seq_b [13] = '{4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2,
                              4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA};
  logic [3:0] seq_s2 [7] = '{4'h6, 4'hD, 4'h5, 4'h7, 4'hB, 4'h8, 4'h2};

  always #5 CLK = ~CLK;

  lfsr_rng #(
    .LFSR_DW(4), .TAPS(4'hC), .LFSR_DEFAULT(4'h1),
    .OUT_DW(4), .STEPS(1), .CNT_DW(8)
  ) dut1 (
    .CLK(CLK), .RST(RST), .I_EN(I_EN), .I_SEED_VLD(I_SEED_VLD),
    .I_SEED(I_SEED), .I_RDY(I_RDY), .O_VLD(o1_vld), .O_DATA(o1_data),
    .O_WRAP(o1_wrap), .O_LOCKUP(o1_lock), .O_SEED_ERR(o1_serr),
    .O_WORD_CNT(o1_cnt)
  );

  lfsr_rng #(
    .LFSR_DW(4), .TAPS(4'hC), .LFSR_DEFAULT(4'h1),
    .OUT_DW(4), .STEPS(2), .CNT_DW(8)
  ) dut2 (
    .CLK(CLK), .RST(RST), .I_EN(I_EN), .I_SEED_VLD(I_SEED_VLD),
    .I_SEED(I_SEED), .I_RDY(I_RDY), .O_VLD(o2_vld), .O_DATA(o2_data),
    .O_WRAP(o2_wrap), .O_LOCKUP(o2_lock), .O_SEED_ERR(o2_serr),
    .O_WORD_CNT(o2_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic sv, input logic [3:0] seed,
                     input logic rdy, input logic vld, input logic [3:0] data,
                     input logic wrap, input logic lock, input logic serr,
                     input logic [7:0] cnt);
    vec_t v;
    v.en = en;  v.sv = sv;  v.seed = seed;  v.rdy = rdy;
    v.vld = vld;  v.data = data;  v.wrap = wrap;  v.lock = lock;
    v.serr = serr;  v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld1"},  32'(o1_vld),  32'h0);
    chk({tag, "_data1"}, 32'(o1_data), 32'h1);
    chk({tag, "_flags1"}, 32'({o1_wrap, o1_lock, o1_serr}), 32'h0);
    chk({tag, "_cnt1"},  32'(o1_cnt),  32'h0);
    chk({tag, "_vld2"},  32'(o2_vld),  32'h0);
    chk({tag, "_data2"}, 32'(o2_data), 32'h1);
    chk({tag, "_flags2"}, 32'({o2_wrap, o2_lock, o2_serr}), 32'h0);
    chk({tag, "_cnt2"},  32'(o2_cnt),  32'h0);
  endtask

  initial begin
    RST = 1'b1;  I_EN = 1'b0;  I_SEED_VLD = 1'b0;  I_SEED = 4'h0;  I_RDY = 1'b0;
    tick();
    tick();
    chk_reset("rst0");
    RST = 1'b0;

    // Free run from reset seed, with a 3-cycle stall on word 6, to the wrap.
    add(1,0,4'h0,1, 1,4'h1,0,0,0,8'd0);
    add(1,0,4'h0,1, 1,4'hC,0,0,0,8'd1);
    add(1,0,4'h0,1, 1,4'h6,0,0,0,8'd2);
    for (int i = 0; i < 3; i++) add(1,0,4'h0,0, 1,4'h6,0,0,0,8'd2);
    for (int i = 0; i < 13; i++) add(1,0,4'h0,1, 1,seq_a[i],(i == 12),0,0,8'(3 + i));
    // Seed strobe in RUN, then I_EN dropped during a stall.
    add(1,1,4'h5,0, 1,4'h1,0,0,1,8'd15);
    add(1,0,4'h0,0, 1,4'h1,0,0,0,8'd15);
    add(0,0,4'h0,0, 1,4'h1,0,0,0,8'd15);
    add(0,0,4'h0,0, 1,4'h1,0,0,0,8'd15);
    add(0,0,4'h0,1, 0,4'hC,0,0,0,8'd16);
    add(0,0,4'h0,1, 0,4'hC,0,0,0,8'd16);
    // Zero seed, then seed A with I_EN in the same cycle, then run to the wrap at A.
    add(0,1,4'h0,0, 0,4'h1,0,1,0,8'd0);
    add(0,0,4'h0,0, 0,4'h1,0,0,0,8'd0);
    add(1,1,4'hA,0, 0,4'hA,0,0,0,8'd0);
    add(1,0,4'h0,1, 1,4'hA,0,0,0,8'd0);
    add(1,0,4'h0,1, 1,4'h5,0,0,0,8'd1);
    add(1,0,4'h0,1, 1,4'hE,0,0,0,8'd2);
    for (int i = 0; i < 13; i++) add(1,0,4'h0,1, 1,seq_b[i],(i == 12),0,0,8'(3 + i));
    add(0,0,4'h0,1, 0,4'h5,0,0,0,8'd16);

    foreach (vq[i]) begin
      I_EN = vq[i].en;  I_SEED_VLD = vq[i].sv;  I_SEED = vq[i].seed;  I_RDY = vq[i].rdy;
      tick();
      chk($sformatf("r%0d_vld", i),  32'(o1_vld),  32'(vq[i].vld));
      chk($sformatf("r%0d_data", i), 32'(o1_data), 32'(vq[i].data));
      chk($sformatf("r%0d_wrap", i), 32'(o1_wrap), 32'(vq[i].wrap));
      chk($sformatf("r%0d_lock", i), 32'(o1_lock), 32'(vq[i].lock));
      chk($sformatf("r%0d_serr", i), 32'(o1_serr), 32'(vq[i].serr));
      chk($sformatf("r%0d_cnt", i),  32'(o1_cnt),  32'(vq[i].cnt));
    end

    // Two shifts per word, then reset mid-stream.
    I_EN = 1'b0;  I_SEED_VLD = 1'b0;  I_RDY = 1'b0;  RST = 1'b1;
    tick();
    chk_reset("rst1");
    RST = 1'b0;  I_EN = 1'b1;  I_RDY = 1'b1;
    tick();
    chk("s2_first_vld",  32'(o2_vld),  32'h1);
    chk("s2_first_data", 32'(o2_data), 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("s2_w%0d_data", i), 32'(o2_data), 32'(seq_s2[i]));
      chk($sformatf("s2_w%0d_cnt", i),  32'(o2_cnt),  32'(i + 1));
    end
    RST = 1'b1;
    tick();
    chk_reset("rst_mid");
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
